// File: rtl/t_toggle_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : t_toggle_debounce
//  Brief    : Synchronises and debounces a push-button, emitting one toggle
//             pulse per press. Optional auto-repeat via macro AUTO_REPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module t_toggle_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic clock,
   input  logic clear_,
   input  logic btn,
   output logic t,
   output logic held
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);

   if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > (2**CNT_W) - 1)) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES out of range");
   end
   if ((REPEAT_CYCLES < 2) || (REPEAT_CYCLES > (2**CNT_W) - 1)) begin : g_bad_repeat
      $error("REPEAT_CYCLES out of range");
   end

   logic             r_s1;
   logic             r_s2;
   logic [CNT_W-1:0] r_cnt;
   state_t           r_state;
   logic             w_btn_s;

`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] c_rpt_last = CNT_W'(REPEAT_CYCLES - 1);
   logic [CNT_W-1:0] r_rpt;
`endif

   assign w_btn_s = r_s2;

   always_ff @(posedge clock or negedge clear_) begin
      if (!clear_) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_cnt   <= '0;
         r_state <= IDLE;
         t       <= 1'b0;
         held    <= 1'b0;
`ifdef AUTO_REPEAT_EN
         r_rpt   <= '0;
`endif
      end else begin
         r_s1 <= btn;
         r_s2 <= r_s1;
         t    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_btn_s) begin
                  r_state <= PRESS_WAIT;
                  r_cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!w_btn_s) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == c_deb_last) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
                  t       <= 1'b1;
                  held    <= 1'b1;
`ifdef AUTO_REPEAT_EN
                  r_rpt   <= '0;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            HELD: begin
               // A release edge takes priority over a coincident repeat tick
               if (!w_btn_s) begin
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= '0;
               end
`ifdef AUTO_REPEAT_EN
               else if (r_rpt == c_rpt_last) begin
                  t     <= 1'b1;
                  r_rpt <= '0;
               end else begin
                  r_rpt <= r_rpt + 1'b1;
               end
`endif
            end
            RELEASE_WAIT: begin
               if (w_btn_s) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
`ifdef AUTO_REPEAT_EN
                  r_rpt   <= '0;
`endif
               end else if (r_cnt == c_deb_last) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  held    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               held    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_t_toggle_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t_toggle_debounce
//  Brief    : Directed self-checking bench for t_toggle_debounce (D=4, R=16).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_t_toggle_debounce;

   logic clock  = 1'b0;
   logic clear_ = 1'b0;
   logic btn    = 1'b0;
   logic t;
   logic held;

   int checks = 0;
   int passed = 0;

   t_toggle_debounce #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (8),
      .REPEAT_CYCLES  (16)
   ) dut (
      .clock (clock),
      .clear_(clear_),
      .btn   (btn),
      .t     (t),
      .held  (held)
   );

   always #5 clock = ~clock;

   // Inputs change 1ns after a rising edge, so the next edge samples them.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic settle_idle();
      btn = 1'b0;
      repeat (14) step();
   endtask

   task automatic test_reset();
      int bad;
      int cnt;
      int first;
      logic held6;
      bad = 0; cnt = 0; first = -1; held6 = 1'b0;
      clear_ = 1'b0;
      btn    = 1'b1;
      #2;
      checks++;
      if (t !== 1'b0) $display("FAIL reset_t: got %b want 0", t);
      else passed++;
      checks++;
      if (held !== 1'b0) $display("FAIL reset_held: got %b want 0", held);
      else passed++;
      repeat (8) begin
         step();
         if (t !== 1'b0 || held !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL reset_hold_outputs: got %0d bad cycles want 0", bad);
      else passed++;
      clear_ = 1'b1;
      for (int e = 0; e < 12; e++) begin
         step();
         if (t === 1'b1) begin
            cnt++;
            if (first < 0) first = e;
         end
         if (e == 6) held6 = held;
      end
      checks++;
      if (cnt !== 1) $display("FAIL reset_release_pulses: got %0d want 1", cnt);
      else passed++;
      checks++;
      if (first !== 6) $display("FAIL reset_release_edge: got %0d want 6", first);
      else passed++;
      checks++;
      if (held6 !== 1'b1) $display("FAIL reset_release_held: got %b want 1", held6);
      else passed++;
      settle_idle();
   endtask

   task automatic test_clean_press();
      int cnt;
      int first;
      int fall;
      int held_drop;
      logic held5;
      cnt = 0; first = -1; fall = -1; held_drop = 0; held5 = 1'b1;
      btn = 1'b1;
      for (int e = 0; e < 40; e++) begin
         step();
         if (t === 1'b1) begin
            cnt++;
            if (first < 0) first = e;
         end
         if (e == 5) held5 = held;
         if (e >= 6 && held !== 1'b1) held_drop++;
      end
      btn = 1'b0;
      for (int e = 0; e < 10; e++) begin
         step();
         if (t === 1'b1) cnt++;
         if (held === 1'b0 && fall < 0) fall = e;
      end
      checks++;
      if (cnt !== 1) $display("FAIL clean_pulse_count: got %0d want 1", cnt);
      else passed++;
      checks++;
      if (first !== 6) $display("FAIL clean_pulse_edge: got %0d want 6", first);
      else passed++;
      checks++;
      if (held5 !== 1'b0) $display("FAIL clean_held_early: got %b want 0", held5);
      else passed++;
      checks++;
      if (held_drop !== 0) $display("FAIL clean_held_steady: got %0d low cycles want 0", held_drop);
      else passed++;
      checks++;
      if (fall !== 6) $display("FAIL clean_release_edge: got %0d want 6", fall);
      else passed++;
      settle_idle();
   endtask

   task automatic test_bounce();
      logic [5:0] pat;
      int cnt;
      int hcnt;
      pat = 6'b111011;  // bit i is the level sampled at edge i
      cnt = 0; hcnt = 0;
      for (int i = 0; i < 6; i++) begin
         btn = pat[i];
         step();
         if (t === 1'b1) cnt++;
         if (held === 1'b1) hcnt++;
      end
      btn = 1'b0;
      repeat (16) begin
         step();
         if (t === 1'b1) cnt++;
         if (held === 1'b1) hcnt++;
      end
      checks++;
      if (cnt !== 0) $display("FAIL bounce_pulses: got %0d want 0", cnt);
      else passed++;
      checks++;
      if (hcnt !== 0) $display("FAIL bounce_held: got %0d high cycles want 0", hcnt);
      else passed++;
      settle_idle();
   endtask

   task automatic test_release_bounce();
      int cnt;
      int extra;
      int low;
      cnt = 0; extra = 0; low = 0;
      btn = 1'b1;
      repeat (10) begin
         step();
         if (t === 1'b1) cnt++;
      end
      btn = 1'b0;
      step();
      step();
      btn = 1'b1;
      repeat (15) begin
         step();
         if (t === 1'b1) extra++;
         if (held !== 1'b1) low++;
      end
      checks++;
      if (cnt !== 1) $display("FAIL relbounce_press_pulse: got %0d want 1", cnt);
      else passed++;
      checks++;
      if (extra !== 0) $display("FAIL relbounce_extra_pulse: got %0d want 0", extra);
      else passed++;
      checks++;
      if (low !== 0) $display("FAIL relbounce_held: got %0d low cycles want 0", low);
      else passed++;
      btn = 1'b0;
      repeat (12) step();
      checks++;
      if (held !== 1'b0) $display("FAIL relbounce_final_release: got %b want 0", held);
      else passed++;
      settle_idle();
   endtask

   task automatic test_reset_mid();
      int bad;
      int cnt;
      int first;
      bad = 0; cnt = 0; first = -1;
      btn = 1'b1;
      for (int e = 0; e <= 4; e++) step();
      clear_ = 1'b0;
      #1;
      if (t !== 1'b0 || held !== 1'b0) bad++;
      for (int e = 5; e <= 7; e++) begin
         step();
         if (t !== 1'b0 || held !== 1'b0) bad++;
      end
      clear_ = 1'b1;
      for (int e = 0; e < 12; e++) begin
         step();
         if (t === 1'b1) begin
            cnt++;
            if (first < 0) first = e;
         end
      end
      checks++;
      if (bad !== 0) $display("FAIL midreset_outputs: got %0d bad samples want 0", bad);
      else passed++;
      checks++;
      if (cnt !== 1) $display("FAIL midreset_pulses: got %0d want 1", cnt);
      else passed++;
      checks++;
      if (first !== 6) $display("FAIL midreset_edge: got %0d want 6", first);
      else passed++;
      settle_idle();
   endtask

`ifdef AUTO_REPEAT_EN
   task automatic test_auto_repeat();
      int cnt;
      int edges[4];
      cnt = 0;
      foreach (edges[k]) edges[k] = -1;
      btn = 1'b1;
      for (int e = 0; e < 60; e++) begin
         step();
         if (t === 1'b1) begin
            if (cnt < 4) edges[cnt] = e;
            cnt++;
         end
      end
      checks++;
      if (cnt !== 4) $display("FAIL repeat_count: got %0d want 4", cnt);
      else passed++;
      checks++;
      if (edges[0] !== 6 || edges[1] !== 22 || edges[2] !== 38 || edges[3] !== 54)
         $display("FAIL repeat_edges: got %0d %0d %0d %0d want 6 22 38 54",
                  edges[0], edges[1], edges[2], edges[3]);
      else passed++;
      settle_idle();
   endtask
`endif

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_bounce();
      test_reset_mid();
`ifdef AUTO_REPEAT_EN
      test_auto_repeat();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/t_toggle_debounce.md
# t_toggle_debounce

Upstream stage for the T flip-flop: converts a raw, bouncing, asynchronous push-button level into a clean single-cycle toggle-enable pulse `t`. The T flip-flop's state changes once per qualified press. The block synchronises the button, debounces both edges with a counter-driven FSM and emits one `t` pulse per press. Optional auto-repeat is available while the button is held.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a press or release. Legal range 1 to 2^`CNT_W`-1.
- `CNT_W`, default 8: width of the debounce counter and the repeat counter.
- `REPEAT_CYCLES`, default 16: period of auto-repeat pulses, in clocks. Used only with `AUTO_REPEAT_EN`. Legal range 2 to 2^`CNT_W`-1.
- `clock`  in  1: single clock; all state is updated on its rising edge.
- `clear_`  in  1: reset, asynchronous, active-low. The system reset generator deasserts it synchronously to `clock`.
- `btn`  in  1: raw button level, asynchronous to `clock`; high = pressed.
- `t`  out  1: registered toggle-enable. High for exactly one clock per accepted press (plus repeats when enabled). Drives the T flip-flop `t` input.
- `held`  out  1: registered; high while the debounced button state is "pressed".

## Operation
- Synchroniser: two flops `s1`, `s2`; `btn_s` = `s2`. Both flops are cleared by `clear_`.
- Debounce counter `cnt` is `CNT_W` bits wide and is cleared on every state change.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE (`held`=0):
  - `btn_s`=1 -> PRESS_WAIT, `cnt`=0.
- PRESS_WAIT (`held`=0):
  - `btn_s`=0 -> IDLE. The bounce is rejected and no pulse is produced.
  - Otherwise, if `cnt`==`DEBOUNCE_CYCLES`-1 -> HELD and `t`=1 on the next cycle.
  - Otherwise `cnt`+1.
- HELD (`held`=1):
  - `btn_s`=0 -> RELEASE_WAIT, `cnt`=0.
- RELEASE_WAIT (`held`=1):
  - `btn_s`=1 -> HELD, with no new `t` pulse.
  - Otherwise, if `cnt`==`DEBOUNCE_CYCLES`-1 -> IDLE.
  - Otherwise `cnt`+1.
- `t` is high only in the first cycle after entering HELD from PRESS_WAIT (and on repeat events). Re-entry into HELD from RELEASE_WAIT never pulses.
- Counters never wrap: the terminal compare always fires before overflow, given the legal parameter range.
- Reset at any time, including mid-debounce:
  - `clear_`=0 immediately forces IDLE and zeroes `cnt`, the repeat counter, `s1`, `s2`, `t` and `held`.
  - After release, a button still held is re-qualified as a fresh press, producing exactly one pulse after the full latency.

## Timing
- Reset values: `t`=0, `held`=0, state IDLE.
- Press latency: let edge 0 be the first rising edge at which `btn` is sampled high.
  - `btn_s`=1 after edge 1.
  - PRESS_WAIT is entered at edge 2.
  - HELD is entered and `t`=1 at edge `DEBOUNCE_CYCLES`+2.
  - `t` returns to 0 at the following edge.
  - With the default `DEBOUNCE_CYCLES`=4: `t` is high between edges 6 and 7.
- `held` rises in the same cycle as `t`.
- Release latency: `held` falls at edge `DEBOUNCE_CYCLES`+2 after the first edge sampling `btn` low, provided `btn` stays low.
- Any glitch of the opposite level reaching `btn_s` during a wait state restarts qualification. Total latency grows accordingly.
- Minimum spacing between two accepted presses is 2·(`DEBOUNCE_CYCLES`+1) clocks.

## Configuration
- `AUTO_REPEAT_EN` defined:
  - A repeat counter runs while in HELD and is cleared on HELD entry.
  - Every `REPEAT_CYCLES` clocks spent in HELD, `t` pulses for one cycle and the counter reloads to 0.
  - The counter freezes in RELEASE_WAIT and clears on re-entry to HELD from RELEASE_WAIT.
  - With defaults, pulses occur at edges 6, 22, 38, … while the button is held.
- `AUTO_REPEAT_EN` undefined:
  - No repeat counter is built.
  - Exactly one `t` pulse per accepted press, regardless of hold duration.

## Test plan
- Reset: `clear_`=0 with `btn`=1 and clock running -> `t`=0, `held`=0 throughout. Release `clear_` -> single `t` pulse 6 clocks after the first edge sampling `btn` high (D=4).
- Clean press: `btn` 0->1 held for 40 clocks, then 0 -> without `AUTO_REPEAT_EN`, exactly one `t` pulse at edge 6. `held` high from edge 6 until 6 clocks after the release sample.
- Bounce rejection: `btn` high for 2 clocks, low for 1, high for 3, then low -> zero `t` pulses and `held` stays 0.
- Release bounce: while in HELD, `btn` low for 2 clocks then high -> `held` stays 1 and no extra `t` pulse.
- Reset mid-debounce: assert `clear_`=0 at edge 4 of a press and release it at edge 7 with `btn` still high -> state IDLE during reset, then one pulse 6 clocks after the first post-reset sample.
- Auto-repeat (`AUTO_REPEAT_EN`, R=16): hold `btn` 60 clocks -> `t` pulses at edges 6, 22, 38 and 54. Chained with the T flip-flop, `q` toggles four times.
